// File: rtl/ysyx_23060025_axi_rd_arbiter_if.sv
// One AXI4 read-address/read-data channel pair, reused for the icache,
// LSU and upstream sides of the read arbiter.
interface ysyx_23060025_axi_rd_arbiter_if #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
);
    logic [ADDR_LEN-1:0] araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [DATA_LEN-1:0] rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/ysyx_23060025_axi_rd_arbiter.sv
// Round-robin merge of the icache and LSU AXI4 read masters, one read in flight.
// Optional read watchdog: define YSYX_23060025_ARB_TIMEOUT_EN.
module ysyx_23060025_axi_rd_arbiter #(
    parameter int          ADDR_LEN      = 32,
    parameter int          DATA_LEN      = 32,
    parameter int unsigned TIMEOUT_LIMIT = 1024
) (
    input  logic clock,
    input  logic reset,
    ysyx_23060025_axi_rd_arbiter_if.slave  inst,
    ysyx_23060025_axi_rd_arbiter_if.slave  data,
    ysyx_23060025_axi_rd_arbiter_if.master out,
    output logic timeout_err_o
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] I_AR = 3'd1;
    localparam logic [2:0] I_R  = 3'd2;
    localparam logic [2:0] D_AR = 3'd3;
    localparam logic [2:0] D_R  = 3'd4;

    localparam logic GNT_INST = 1'b0;
    localparam logic GNT_DATA = 1'b1;

    logic [2:0] state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       is_inst;
    logic       ar_hs;
    logic       r_hs;
    logic       to_q, to_d;

    assign is_inst = (state_q == I_AR) || (state_q == I_R);
    assign ar_hs   = out.arvalid && out.arready;
    assign r_hs    = out.rvalid && out.rready;

    // Only the interface fields this block never consumes.
    logic unused_ok;
    assign unused_ok = ^{inst.arburst, data.arlen, data.arburst,
                         TIMEOUT_LIMIT[0]};

`ifdef YSYX_23060025_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_LIMIT + 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic                busy;

    assign busy = (state_q != IDLE);

    always_comb begin
        cnt_d  = cnt_q;
        to_d   = to_q;
        err_d  = err_q;
        addr_d = addr_q;
        if (state_q == IDLE && state_d == I_AR)
            addr_d = inst.araddr;
        else if (state_q == IDLE && state_d == D_AR)
            addr_d = data.araddr;
        if (to_q) begin
            if (state_d == IDLE)
                to_d = 1'b0;
        end else if (state_d != state_q && state_d != IDLE) begin
            cnt_d = '0;
        end else if (busy) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(TIMEOUT_LIMIT - 1)) begin
                to_d  = 1'b1;
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            to_q   <= 1'b0;
            err_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            to_q   <= to_d;
            err_q  <= err_d;
            addr_q <= addr_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset && !to_q && to_d)
            $display("axi_rd_arbiter: read timeout master=%s addr=0x%h",
                     is_inst ? "inst" : "data", addr_q);
    end
`endif

    assign timeout_err_o = err_q;
`else
    assign to_q          = 1'b0;
    assign to_d          = 1'b0;
    assign timeout_err_o = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (inst.arvalid && data.arvalid) begin
                    if (last_grant_q == GNT_DATA) begin
                        state_d      = I_AR;
                        last_grant_d = GNT_INST;
                    end else begin
                        state_d      = D_AR;
                        last_grant_d = GNT_DATA;
                    end
                end else if (inst.arvalid) begin
                    state_d      = I_AR;
                    last_grant_d = GNT_INST;
                end else if (data.arvalid) begin
                    state_d      = D_AR;
                    last_grant_d = GNT_DATA;
                end
            end
            I_AR: if (ar_hs) state_d = I_R;
            I_R:  if (r_hs && out.rlast) state_d = IDLE;
            D_AR: if (ar_hs) state_d = D_R;
            D_R:  if (r_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // The synthetic error beat ends the transaction on the master's rready.
        if (to_q) begin
            state_d = state_q;
            if (is_inst ? inst.rready : data.rready)
                state_d = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_DATA;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        out.araddr   = '0;
        out.arlen    = 8'd0;
        out.arsize   = 3'd0;
        out.arburst  = 2'b01;
        out.arvalid  = 1'b0;
        out.rready   = 1'b0;
        inst.arready = 1'b0;
        inst.rdata   = '0;
        inst.rresp   = 2'b00;
        inst.rlast   = 1'b0;
        inst.rvalid  = 1'b0;
        data.arready = 1'b0;
        data.rdata   = '0;
        data.rresp   = 2'b00;
        data.rlast   = 1'b0;
        data.rvalid  = 1'b0;
        unique case (state_q)
            I_AR: begin
                out.araddr   = inst.araddr;
                out.arlen    = inst.arlen;
                out.arsize   = inst.arsize;
                out.arvalid  = inst.arvalid;
                inst.arready = out.arready;
            end
            I_R: begin
                inst.rdata  = out.rdata;
                inst.rresp  = out.rresp;
                inst.rlast  = out.rlast;
                inst.rvalid = out.rvalid;
                out.rready  = inst.rready;
            end
            D_AR: begin
                out.araddr   = data.araddr;
                out.arsize   = data.arsize;
                out.arvalid  = data.arvalid;
                data.arready = out.arready;
            end
            D_R: begin
                data.rdata  = out.rdata;
                data.rresp  = out.rresp;
                data.rlast  = 1'b1;
                data.rvalid = out.rvalid;
                out.rready  = data.rready;
            end
            default: ;
        endcase
        if (to_q) begin
            out.arvalid  = 1'b0;
            out.rready   = 1'b0;
            inst.arready = 1'b0;
            data.arready = 1'b0;
            if (is_inst) begin
                inst.rvalid = 1'b1;
                inst.rresp  = 2'b11;
                inst.rlast  = 1'b1;
                inst.rdata  = '0;
            end else begin
                data.rvalid = 1'b1;
                data.rresp  = 2'b11;
                data.rlast  = 1'b1;
                data.rdata  = '0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060025_axi_rd_arbiter.sv
// Directed bench for the AXI read arbiter: bursts, back-pressure,
// round-robin ties, mid-transaction reset and (optionally) the watchdog.
module tb_ysyx_23060025_axi_rd_arbiter;

    logic clock = 1'b0;
    logic reset;
    logic timeout_err_o;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    ysyx_23060025_axi_rd_arbiter_if #(.ADDR_LEN(32), .DATA_LEN(32)) inst_if ();
    ysyx_23060025_axi_rd_arbiter_if #(.ADDR_LEN(32), .DATA_LEN(32)) data_if ();
    ysyx_23060025_axi_rd_arbiter_if #(.ADDR_LEN(32), .DATA_LEN(32)) out_if ();

    ysyx_23060025_axi_rd_arbiter #(
        .ADDR_LEN      (32),
        .DATA_LEN      (32),
        .TIMEOUT_LIMIT (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .inst          (inst_if),
        .data          (data_if),
        .out           (out_if),
        .timeout_err_o (timeout_err_o)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        inst_if.araddr  = '0;
        inst_if.arlen   = 8'd0;
        inst_if.arsize  = 3'd0;
        inst_if.arburst = 2'b01;
        inst_if.arvalid = 1'b0;
        inst_if.rready  = 1'b0;
        data_if.araddr  = '0;
        data_if.arlen   = 8'd0;
        data_if.arsize  = 3'd0;
        data_if.arburst = 2'b01;
        data_if.arvalid = 1'b0;
        data_if.rready  = 1'b0;
        out_if.arready  = 1'b0;
        out_if.rdata    = '0;
        out_if.rresp    = 2'b00;
        out_if.rlast    = 1'b0;
        out_if.rvalid   = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_out_arvalid", out_if.arvalid, 0);
        check("rst_out_rready", out_if.rready, 0);
        check("rst_inst_arready", inst_if.arready, 0);
        check("rst_data_arready", data_if.arready, 0);
        check("rst_inst_rvalid", inst_if.rvalid, 0);
        check("rst_data_rvalid", data_if.rvalid, 0);
        check("rst_arburst", out_if.arburst, 2'b01);
        check("rst_araddr", out_if.araddr, 0);
        check("rst_err", timeout_err_o, 0);

        // Instruction burst of 4 beats.
        inst_if.araddr  = 32'h3000_0000;
        inst_if.arlen   = 8'd3;
        inst_if.arsize  = 3'd2;
        inst_if.arvalid = 1'b1;
        #1;
        check("i_grant_latency", out_if.arvalid, 0);
        tick();
        check("i_out_arvalid", out_if.arvalid, 1);
        check("i_out_araddr", out_if.araddr, 32'h3000_0000);
        check("i_out_arlen", out_if.arlen, 3);
        check("i_out_arsize", out_if.arsize, 2);
        check("i_out_arburst", out_if.arburst, 2'b01);
        check("i_arready_low", inst_if.arready, 0);
        out_if.arready = 1'b1;
        #1;
        check("i_arready_follow", inst_if.arready, 1);
        check("i_data_arready", data_if.arready, 0);
        tick();
        inst_if.arvalid = 1'b0;
        out_if.arready  = 1'b0;
        inst_if.rready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            out_if.rvalid = 1'b1;
            out_if.rdata  = 32'h100 + i;
            out_if.rlast  = (i == 3);
            #1;
            check("i_rvalid", inst_if.rvalid, 1);
            check("i_rdata", inst_if.rdata, 32'h100 + i);
            check("i_rlast", inst_if.rlast, (i == 3));
            check("i_out_rready", out_if.rready, 1);
            check("i_data_rvalid", data_if.rvalid, 0);
            check("i_data_arready_r", data_if.arready, 0);
            tick();
        end
        out_if.rvalid = 1'b0;
        out_if.rlast  = 1'b0;
        inst_if.rready = 1'b0;
        #1;
        check("i_idle_rready", out_if.rready, 0);
        check("i_idle_rvalid", inst_if.rvalid, 0);
        check("i_idle_arvalid", out_if.arvalid, 0);

        // Single data read, LSU stalls rready for 3 cycles.
        data_if.araddr  = 32'h0f00_0004;
        data_if.arsize  = 3'd2;
        data_if.arvalid = 1'b1;
        tick();
        check("d_out_arvalid", out_if.arvalid, 1);
        check("d_out_araddr", out_if.araddr, 32'h0f00_0004);
        check("d_out_arlen", out_if.arlen, 0);
        check("d_out_arsize", out_if.arsize, 2);
        out_if.arready = 1'b1;
        #1;
        check("d_arready", data_if.arready, 1);
        check("d_inst_arready", inst_if.arready, 0);
        tick();
        data_if.arvalid = 1'b0;
        out_if.arready  = 1'b0;
        out_if.rvalid   = 1'b1;
        out_if.rdata    = 32'hdead_beef;
        out_if.rlast    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("d_stall_rvalid", data_if.rvalid, 1);
            check("d_stall_rdata", data_if.rdata, 32'hdead_beef);
            check("d_stall_rready", out_if.rready, 0);
            check("d_inst_rvalid", inst_if.rvalid, 0);
            tick();
        end
        data_if.rready = 1'b1;
        #1;
        check("d_rready", out_if.rready, 1);
        tick();
        out_if.rvalid  = 1'b0;
        data_if.rready = 1'b0;
        #1;
        check("d_idle_rvalid", data_if.rvalid, 0);

        // Tie right after reset: inst first, then data, then inst again.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        inst_if.araddr  = 32'h0000_0100;
        inst_if.arlen   = 8'd0;
        inst_if.arvalid = 1'b1;
        data_if.araddr  = 32'h0000_0200;
        data_if.arvalid = 1'b1;
        tick();
        check("rr1_addr", out_if.araddr, 32'h0000_0100);
        check("rr1_data_arready", data_if.arready, 0);
        out_if.arready = 1'b1;
        tick();
        inst_if.arvalid = 1'b0;
        out_if.arready  = 1'b0;
        out_if.rvalid   = 1'b1;
        out_if.rlast    = 1'b1;
        inst_if.rready  = 1'b1;
        tick();
        out_if.rvalid  = 1'b0;
        inst_if.rready = 1'b0;
        #1;
        check("rr_gap_arvalid", out_if.arvalid, 0);
        tick();
        check("rr2_addr", out_if.araddr, 32'h0000_0200);
        check("rr2_arvalid", out_if.arvalid, 1);
        out_if.arready = 1'b1;
        tick();
        out_if.arready  = 1'b0;
        inst_if.arvalid = 1'b1;
        out_if.rvalid   = 1'b1;
        data_if.rready  = 1'b1;
        tick();
        out_if.rvalid  = 1'b0;
        data_if.rready = 1'b0;
        tick();
        check("rr3_addr", out_if.araddr, 32'h0000_0100);

        // Upstream AR back-pressure for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            check("bp_arvalid", out_if.arvalid, 1);
            check("bp_araddr", out_if.araddr, 32'h0000_0100);
            check("bp_inst_arready", inst_if.arready, 0);
            check("bp_data_arready", data_if.arready, 0);
            tick();
        end
        out_if.arready = 1'b1;
        tick();
        inst_if.arvalid = 1'b0;
        data_if.arvalid = 1'b0;
        out_if.arready  = 1'b0;
        out_if.rvalid   = 1'b1;
        inst_if.rready  = 1'b1;
        tick();
        out_if.rvalid  = 1'b0;
        inst_if.rready = 1'b0;

        // Reset in the middle of a 4-beat inst burst.
        inst_if.araddr  = 32'h3000_0040;
        inst_if.arlen   = 8'd3;
        inst_if.arvalid = 1'b1;
        tick();
        out_if.arready = 1'b1;
        tick();
        inst_if.arvalid = 1'b0;
        out_if.arready  = 1'b0;
        out_if.rvalid   = 1'b1;
        out_if.rlast    = 1'b0;
        inst_if.rready  = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("mr_inst_rvalid", inst_if.rvalid, 0);
        check("mr_out_rready", out_if.rready, 0);
        check("mr_out_arvalid", out_if.arvalid, 0);
        check("mr_inst_arready", inst_if.arready, 0);
        out_if.rvalid   = 1'b0;
        inst_if.rready  = 1'b0;
        data_if.araddr  = 32'h0f00_0010;
        data_if.arvalid = 1'b1;
        #1;
        check("mr_latency", out_if.arvalid, 0);
        tick();
        check("mr_d_arvalid", out_if.arvalid, 1);
        check("mr_d_araddr", out_if.araddr, 32'h0f00_0010);
        out_if.arready = 1'b1;
        tick();
        data_if.arvalid = 1'b0;
        out_if.arready  = 1'b0;
        out_if.rvalid   = 1'b1;
        out_if.rlast    = 1'b1;
        out_if.rdata    = 32'h0000_5a5a;
        data_if.rready  = 1'b1;
        #1;
        check("mr_d_rdata", data_if.rdata, 32'h0000_5a5a);
        check("mr_d_rvalid", data_if.rvalid, 1);
        tick();
        out_if.rvalid  = 1'b0;
        data_if.rready = 1'b0;
        #1;
        check("mr_d_done", data_if.rvalid, 0);

`ifdef YSYX_23060025_ARB_TIMEOUT_EN
        data_if.araddr  = 32'h0f00_0020;
        data_if.arvalid = 1'b1;
        tick();
        n = 0;
        while (!data_if.rvalid && n < 64) begin
            tick();
            n++;
        end
        check("to_cycles", n, 16);
        check("to_rresp", data_if.rresp, 2'b11);
        check("to_rdata", data_if.rdata, 0);
        check("to_out_arvalid", out_if.arvalid, 0);
        check("to_err", timeout_err_o, 1);
        data_if.arvalid = 1'b0;
        data_if.rready  = 1'b1;
        tick();
        data_if.rready = 1'b0;
        #1;
        check("to_idle_rvalid", data_if.rvalid, 0);
        tick();
        check("to_err_sticky", timeout_err_o, 1);
        check("to_idle_arvalid", out_if.arvalid, 0);
`else
        n = 0;
        check("no_to_err", timeout_err_o, n);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
